// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// controller states and small decode helpers.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_e;

    // Operations whose operands are two's-complement
    function automatic logic is_signed_op(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    // Operations that run the restoring-division datapath
    function automatic logic is_div_op(input logic [1:0] op);
        return (op == OP_DIVU) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/result bundle between the datapath controller and the multiply/divide unit.
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/addsub_n.sv
// N-bit adder/subtractor: subtraction inverts the B operand and injects a carry of one.
module addsub_n #(
    parameter int N = 33
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] y
);

    logic [N-1:0] b_eff_s;
    logic [N-1:0] cin_s;

    // Select true or complemented B and the matching carry-in
    always_comb begin
        if (sub) begin
            b_eff_s = ~b;
            cin_s   = {{(N-1){1'b0}}, 1'b1};
        end else begin
            b_eff_s = b;
            cin_s   = {N{1'b0}};
        end
    end

    assign y = a + b_eff_s + cin_s;

endmodule

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide unit: one result bit per cycle, shift-add multiply,
// restoring divide, sign correction in a single FIX cycle, results on hi/lo.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    muldiv_seq_if.slave bus
);

    localparam int                 CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH);
    localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic             dbz_pend_q, dbz_pend_d;   // divisor was zero at load
    logic [WIDTH-1:0] opnd_q, opnd_d;           // multiplicand or divisor magnitude
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;       // product upper half / partial remainder
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;       // multiplier shifting out / dividend-to-quotient
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             sign_a_s, sign_b_s;
    logic [WIDTH-1:0] mag_a_s, mag_b_s;
    logic [WIDTH:0]   rem_sh_s, add_a_s, add_b_s, add_y_s, mul_sum_s;
    logic             add_sub_s;
    logic [2*WIDTH-1:0] prod_s, prod_neg_s;
    logic [WIDTH-1:0] quo_neg_s, rem_neg_s;

    // Signs and unsigned magnitudes of the operands presented with start
    always_comb begin
        sign_a_s = is_signed_op(bus.op) & bus.a[WIDTH-1];
        sign_b_s = is_signed_op(bus.op) & bus.b[WIDTH-1];
        if (sign_a_s) begin
            mag_a_s = ~bus.a + ONE_W;
        end else begin
            mag_a_s = bus.a;
        end
        if (sign_b_s) begin
            mag_b_s = ~bus.b + ONE_W;
        end else begin
            mag_b_s = bus.b;
        end
    end

    // Feed the shared adder: accumulate for multiply, trial subtract for divide
    always_comb begin
        rem_sh_s = {acc_hi_q, acc_lo_q[WIDTH-1]};
        add_b_s  = {1'b0, opnd_q};
        if (is_div_op(op_q)) begin
            add_a_s   = rem_sh_s;
            add_sub_s = 1'b1;
        end else begin
            add_a_s   = {1'b0, acc_hi_q};
            add_sub_s = 1'b0;
        end
    end

    addsub_n #(
        .N (WIDTH + 1)
    ) u_addsub (
        .a   (add_a_s),
        .b   (add_b_s),
        .sub (add_sub_s),
        .y   (add_y_s)
    );

    // Two's-complement forms of the raw result used by the sign fix-up
    always_comb begin
        prod_s     = {acc_hi_q, acc_lo_q};
        prod_neg_s = ~prod_s + ONE_2W;
        quo_neg_s  = ~acc_lo_q + ONE_W;
        rem_neg_s  = ~acc_hi_q + ONE_W;
    end

    // Controller next state plus datapath and output next values
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        dbz_pend_d = dbz_pend_q;
        opnd_d     = opnd_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        dbz_d      = dbz_q;
        mul_sum_s  = {1'b0, acc_hi_q};

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d    = RUN;
                    cnt_d      = {CW{1'b0}};
                    op_d       = bus.op;
                    sign_a_d   = sign_a_s;
                    sign_b_d   = sign_b_s;
                    dbz_pend_d = is_div_op(bus.op) && (bus.b == {WIDTH{1'b0}});
                    dbz_d      = 1'b0;
                    acc_hi_d   = {WIDTH{1'b0}};
                    if (is_div_op(bus.op)) begin
                        opnd_d   = mag_b_s;
                        acc_lo_d = mag_a_s;
                    end else begin
                        opnd_d   = mag_a_s;
                        acc_lo_d = mag_b_s;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            RUN: begin
                cnt_d = cnt_q + CNT_ONE;
                if (is_div_op(op_q)) begin
                    // Non-negative trial difference: keep it and emit a quotient one
                    if (!add_y_s[WIDTH]) begin
                        acc_hi_d = add_y_s[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi_d = rem_sh_s[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    if (acc_lo_q[0]) begin
                        mul_sum_s = add_y_s;
                    end else begin
                        mul_sum_s = {1'b0, acc_hi_q};
                    end
                    acc_hi_d = mul_sum_s[WIDTH:1];
                    acc_lo_d = {mul_sum_s[0], acc_lo_q[WIDTH-1:1]};
                end
                if (cnt_d == CNT_LAST) begin
                    state_d = FIX;
                end else begin
                    state_d = RUN;
                end
            end

            FIX: begin
                state_d = DONE;
                done_d  = 1'b1;
                dbz_d   = dbz_pend_q;
                if (is_div_op(op_q)) begin
                    if (dbz_pend_q) begin
                        lo_d = {WIDTH{1'b1}};
                    end else if (sign_a_q ^ sign_b_q) begin
                        lo_d = quo_neg_s;
                    end else begin
                        lo_d = acc_lo_q;
                    end
                    // Remainder follows the dividend's sign (truncating division)
                    if (sign_a_q) begin
                        hi_d = rem_neg_s;
                    end else begin
                        hi_d = acc_hi_q;
                    end
                end else begin
                    if (sign_a_q ^ sign_b_q) begin
                        {hi_d, lo_d} = prod_neg_s;
                    end else begin
                        {hi_d, lo_d} = prod_s;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN) || (state_d == FIX);
    end

    // All state and output registers; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= {CW{1'b0}};
            op_q       <= 2'b00;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            dbz_pend_q <= 1'b0;
            opnd_q     <= {WIDTH{1'b0}};
            acc_hi_q   <= {WIDTH{1'b0}};
            acc_lo_q   <= {WIDTH{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            hi_q       <= {WIDTH{1'b0}};
            lo_q       <= {WIDTH{1'b0}};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            dbz_pend_q <= dbz_pend_d;
            opnd_q     <= opnd_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dbz_q      <= dbz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq at WIDTH=32 and WIDTH=8, using an
// arithmetic reference model (native *, / and %) for expected hi/lo.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    muldiv_seq_if #(.WIDTH(32)) i32 ();
    muldiv_seq_if #(.WIDTH(8))  i8  ();

    muldiv_seq #(.WIDTH(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(i32));
    muldiv_seq #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(i8));

    always #5 clk = ~clk;

    // Reference: full-width products and truncating division on sign-extended values
    function automatic void ref_model(input int w, input logic [1:0] op,
                                      input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] hi, output logic [31:0] lo,
                                      output logic dz);
        logic [63:0] mask, ua, ub, p;
        longint sa, sb, q, r;
        mask = (64'd1 << w) - 64'd1;
        ua = {32'd0, a} & mask;
        ub = {32'd0, b} & mask;
        sa = longint'(ua);
        sb = longint'(ub);
        if (op[0] && ua[w-1]) sa = sa - longint'(64'd1 << w);
        if (op[0] && ub[w-1]) sb = sb - longint'(64'd1 << w);
        dz = 1'b0;
        if (!op[1]) begin
            if (op[0]) p = 64'(sa * sb);
            else       p = ua * ub;
            lo = 32'(p & mask);
            hi = 32'((p >> w) & mask);
        end else if (ub == 64'd0) begin
            dz = 1'b1;
            hi = 32'(ua);
            lo = 32'(mask);
        end else begin
            if (op[0]) begin
                q = sa / sb;
                r = sa % sb;
            end else begin
                q = longint'(ua / ub);
                r = longint'(ua % ub);
            end
            lo = 32'(64'(q) & mask);
            hi = 32'(64'(r) & mask);
        end
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(1, 100));
            default: return $urandom;
        endcase
    endfunction

    // Issue one request from the current negedge; return at the done negedge.
    // lat counts edges after the accepting edge; -1 means done never came.
    task automatic run32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int bcyc, output logic busy0, output logic dbz0);
        i32.start = 1'b1; i32.op = op; i32.a = a; i32.b = b;
        @(negedge clk);
        i32.start = 1'b0; i32.a = $urandom; i32.b = $urandom; i32.op = 2'($urandom);
        busy0 = i32.busy; dbz0 = i32.div_by_zero;
        lat = -1; bcyc = 0;
        for (int k = 0; k < 60; k++) begin
            if (i32.done) begin
                lat = k;
                break;
            end
            if (i32.busy) bcyc++;
            @(negedge clk);
        end
    endtask

    task automatic run8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output int bcyc);
        i8.start = 1'b1; i8.op = op; i8.a = a; i8.b = b;
        @(negedge clk);
        i8.start = 1'b0; i8.a = 8'($urandom); i8.b = 8'($urandom);
        lat = -1; bcyc = 0;
        for (int k = 0; k < 30; k++) begin
            if (i8.done) begin
                lat = k;
                break;
            end
            if (i8.busy) bcyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (i32.busy !== 1'b0 || i32.done !== 1'b0 || i32.div_by_zero !== 1'b0) begin
            errors++; $display("FAIL reset_flags32: got busy=%b done=%b dz=%b expected 0 0 0", i32.busy, i32.done, i32.div_by_zero); end
        checks++; if (i32.hi !== 32'd0 || i32.lo !== 32'd0) begin
            errors++; $display("FAIL reset_hilo32: got hi=%h lo=%h expected 0 0", i32.hi, i32.lo); end
        checks++; if (i8.busy !== 1'b0 || i8.done !== 1'b0 || i8.hi !== 8'd0 || i8.lo !== 8'd0 || i8.div_by_zero !== 1'b0) begin
            errors++; $display("FAIL reset8: got busy=%b done=%b hi=%h lo=%h dz=%b expected all 0", i8.busy, i8.done, i8.hi, i8.lo, i8.div_by_zero); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_multu_max();
        int lat, bc; logic b0, d0;
        run32(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc, b0, d0);
        checks++; if (lat !== 33) begin errors++; $display("FAIL multu_latency: got %0d expected 33", lat); end
        checks++; if (bc !== 33 || b0 !== 1'b1) begin errors++; $display("FAIL multu_busy: got %0d cycles first=%b expected 33 1", bc, b0); end
        checks++; if (i32.hi !== 32'hFFFF_FFFE || i32.lo !== 32'h0000_0001) begin
            errors++; $display("FAIL multu_result: got hi=%h lo=%h expected fffffffe 00000001", i32.hi, i32.lo); end
        checks++; if (i32.busy !== 1'b0) begin errors++; $display("FAIL multu_busy_at_done: got %b expected 0", i32.busy); end
        @(negedge clk);
        checks++; if (i32.done !== 1'b0 || i32.busy !== 1'b0) begin
            errors++; $display("FAIL done_pulse: got done=%b busy=%b expected 0 0", i32.done, i32.busy); end
    endtask

    task automatic test_signed();
        int lat, bc; logic b0, d0;
        run32(OP_MULT, 32'hFFFF_FFF9, 32'd6, lat, bc, b0, d0);
        checks++; if (lat !== 33 || i32.hi !== 32'hFFFF_FFFF || i32.lo !== 32'hFFFF_FFD6) begin
            errors++; $display("FAIL mult_neg7x6: got lat=%0d hi=%h lo=%h expected 33 ffffffff ffffffd6", lat, i32.hi, i32.lo); end
        run32(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, bc, b0, d0);
        checks++; if (lat !== 33 || i32.hi !== 32'hFFFF_FFFF || i32.lo !== 32'hFFFF_FFFD || i32.div_by_zero !== 1'b0) begin
            errors++; $display("FAIL div_neg7by2: got lat=%0d hi=%h lo=%h dz=%b expected 33 ffffffff fffffffd 0", lat, i32.hi, i32.lo, i32.div_by_zero); end
    endtask

    task automatic test_div_zero();
        int lat, bc; logic b0, d0;
        run32(OP_DIVU, 32'd100, 32'd0, lat, bc, b0, d0);
        checks++; if (lat !== 33 || i32.hi !== 32'd100 || i32.lo !== 32'hFFFF_FFFF || i32.div_by_zero !== 1'b1) begin
            errors++; $display("FAIL divu_by_zero: got lat=%0d hi=%h lo=%h dz=%b expected 33 00000064 ffffffff 1", lat, i32.hi, i32.lo, i32.div_by_zero); end
        run32(OP_MULTU, 32'd3, 32'd5, lat, bc, b0, d0);
        checks++; if (d0 !== 1'b0 || b0 !== 1'b1) begin
            errors++; $display("FAIL dz_clear_on_start: got dz=%b busy=%b expected 0 1", d0, b0); end
        checks++; if (lat !== 33 || i32.hi !== 32'd0 || i32.lo !== 32'd15) begin
            errors++; $display("FAIL multu_3x5: got lat=%0d hi=%h lo=%h expected 33 0 f", lat, i32.hi, i32.lo); end
        repeat (3) @(negedge clk);
        checks++; if (i32.hi !== 32'd0 || i32.lo !== 32'd15 || i32.done !== 1'b0) begin
            errors++; $display("FAIL hold_hilo: got hi=%h lo=%h done=%b expected 0 f 0", i32.hi, i32.lo, i32.done); end
    endtask

    task automatic test_div_overflow();
        int lat, bc; logic b0, d0;
        run32(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc, b0, d0);
        checks++; if (lat !== 33 || i32.hi !== 32'd0 || i32.lo !== 32'h8000_0000 || i32.div_by_zero !== 1'b0) begin
            errors++; $display("FAIL div_minneg_by_m1: got lat=%0d hi=%h lo=%h dz=%b expected 33 0 80000000 0", lat, i32.hi, i32.lo, i32.div_by_zero); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, eh, el; logic ed; int nd;
        a = $urandom; b = $urandom;
        ref_model(32, OP_MULTU, a, b, eh, el, ed);
        i32.start = 1'b1; i32.op = OP_MULTU; i32.a = a; i32.b = b;
        @(negedge clk);
        nd = 0;
        for (int k = 0; k < 140; k++) begin
            if (k == 101) i32.start = 1'b0;
            if (k < 101) begin
                checks++; if (i32.busy !== !i32.done) begin
                    errors++; $display("FAIL b2b_busy k=%0d: got busy=%b done=%b expected busy=!done", k, i32.busy, i32.done); end
            end
            if (i32.done) begin
                checks++; if (k !== 33 + 34 * nd) begin
                    errors++; $display("FAIL b2b_spacing: got done at %0d expected %0d", k, 33 + 34 * nd); end
                checks++; if (i32.hi !== eh || i32.lo !== el) begin
                    errors++; $display("FAIL b2b_result: got hi=%h lo=%h expected %h %h", i32.hi, i32.lo, eh, el); end
                nd++;
            end
            @(negedge clk);
        end
        checks++; if (nd !== 3) begin errors++; $display("FAIL b2b_count: got %0d dones expected 3", nd); end
    endtask

    task automatic test_ignore_busy();
        logic [31:0] a, b, eh, el; logic ed; int nd, kd;
        a = $urandom; b = 32'($urandom_range(1, 65535));
        ref_model(32, OP_DIVU, a, b, eh, el, ed);
        i32.start = 1'b1; i32.op = OP_DIVU; i32.a = a; i32.b = b;
        @(negedge clk);
        nd = 0; kd = -1;
        for (int k = 0; k < 80; k++) begin
            if (k == 5 || k == 20) begin
                i32.start = 1'b1; i32.op = OP_MULT; i32.a = $urandom; i32.b = $urandom;
            end else begin
                i32.start = 1'b0;
            end
            if (i32.done) begin
                if (nd == 0) kd = k;
                nd++;
            end
            @(negedge clk);
        end
        checks++; if (nd !== 1 || kd !== 33) begin
            errors++; $display("FAIL ignore_busy_done: got %0d dones first at %0d expected 1 at 33", nd, kd); end
        checks++; if (i32.hi !== eh || i32.lo !== el) begin
            errors++; $display("FAIL ignore_busy_result: got hi=%h lo=%h expected %h %h", i32.hi, i32.lo, eh, el); end
    endtask

    task automatic test_reset_mid_run();
        int lat, bc, nd; logic b0, d0;
        logic [31:0] a, b, eh, el; logic ed;
        i32.start = 1'b1; i32.op = OP_MULTU; i32.a = $urandom | 32'h1; i32.b = $urandom | 32'h1;
        @(negedge clk);
        i32.start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (i32.busy !== 1'b0 || i32.done !== 1'b0 || i32.hi !== 32'd0 || i32.lo !== 32'd0) begin
            errors++; $display("FAIL reset_mid_run: got busy=%b done=%b hi=%h lo=%h expected 0 0 0 0", i32.busy, i32.done, i32.hi, i32.lo); end
        rst_n = 1'b1;
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (i32.done) nd++;
        end
        checks++; if (nd !== 0) begin errors++; $display("FAIL reset_no_done: got %0d dones expected 0", nd); end
        a = $urandom; b = $urandom;
        ref_model(32, OP_MULT, a, b, eh, el, ed);
        run32(OP_MULT, a, b, lat, bc, b0, d0);
        checks++; if (lat !== 33 || i32.hi !== eh || i32.lo !== el) begin
            errors++; $display("FAIL after_reset_op: got lat=%0d hi=%h lo=%h expected 33 %h %h", lat, i32.hi, i32.lo, eh, el); end
    endtask

    task automatic test_random32();
        int lat, bc; logic b0, d0;
        logic [1:0] op; logic [31:0] a, b, eh, el; logic ed;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3)); a = pick32(); b = pick32();
            ref_model(32, op, a, b, eh, el, ed);
            run32(op, a, b, lat, bc, b0, d0);
            checks++; if (lat !== 33 || bc !== 33 || i32.hi !== eh || i32.lo !== el || i32.div_by_zero !== ed) begin
                errors++; $display("FAIL rand32 op=%0d a=%h b=%h: got lat=%0d busy=%0d hi=%h lo=%h dz=%b expected 33 33 %h %h %b",
                                   op, a, b, lat, bc, i32.hi, i32.lo, i32.div_by_zero, eh, el, ed); end
        end
    endtask

    task automatic test_width8();
        int lat, bc;
        logic [1:0] op; logic [7:0] a, b; logic [31:0] eh, el; logic ed;
        run8(OP_DIVU, 8'd200, 8'd7, lat, bc);
        checks++; if (lat !== 9 || bc !== 9 || i8.lo !== 8'd28 || i8.hi !== 8'd4) begin
            errors++; $display("FAIL w8_divu_200_7: got lat=%0d busy=%0d lo=%0d hi=%0d expected 9 9 28 4", lat, bc, i8.lo, i8.hi); end
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a = (i % 5 == 0) ? 8'h80 : 8'($urandom);
            b = (i % 7 == 0) ? 8'h00 : ((i % 6 == 0) ? 8'hFF : 8'($urandom));
            ref_model(8, op, {24'd0, a}, {24'd0, b}, eh, el, ed);
            run8(op, a, b, lat, bc);
            checks++; if (lat !== 9 || i8.hi !== eh[7:0] || i8.lo !== el[7:0] || i8.div_by_zero !== ed) begin
                errors++; $display("FAIL rand8 op=%0d a=%h b=%h: got lat=%0d hi=%h lo=%h dz=%b expected 9 %h %h %b",
                                   op, a, b, lat, i8.hi, i8.lo, i8.div_by_zero, eh[7:0], el[7:0], ed); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        i32.start = 1'b0; i32.op = 2'b00; i32.a = 32'd0; i32.b = 32'd0;
        i8.start  = 1'b0; i8.op  = 2'b00; i8.a  = 8'd0;  i8.b  = 8'd0;
        test_reset();
        test_multu_max();
        test_signed();
        test_div_zero();
        test_div_overflow();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid_run();
        test_random32();
        test_width8();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
